router_input_port: RTL and testbench

Parametrised successor to the 16-output serial FSM/decoder input port for the router. One serial input (frame_n/valid_n/din) is decoded into one of N_PORTS serial outputs. Unlike the 16-output original, it buffers payload bits in an internal bit-FIFO while the selected output is busy, drops packets on buffer overflow or early abort, and reports packet completion and drop.

---
 rtl/router_input_port.sv | 232 +++++++++++++++++++++++
 tb/tb_router_input_port.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// router_input_port: decodes a serial LSB-first address, buffers payload bits in a bit-FIFO
// and replays them on the selected serial output once that output is free.
module router_input_port #(
    parameter int N_PORTS    = 16,
    parameter int PAD_CYCLES = 5,
    parameter int BUF_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_n,
    input  logic               valid_n,
    input  logic               din,
    input  logic [N_PORTS-1:0] busy,
    output logic [N_PORTS-1:0] frameo_n,
    output logic [N_PORTS-1:0] valido_n,
    output logic [N_PORTS-1:0] dout,
    output logic               idle,
    output logic               pkt_done,
    output logic               pkt_drop
);
    localparam int ADDR_W = $clog2(N_PORTS);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = $clog2(PAD_CYCLES + ADDR_W + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_DATA,
        S_DRAIN,
        S_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               grant_q, grant_d;
    logic               active_q, active_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     level_q, level_d;
    logic [1:0]         mem_q [BUF_DEPTH];
    logic [N_PORTS-1:0] frameo_q, frameo_d;
    logic [N_PORTS-1:0] valido_q, valido_d;
    logic [N_PORTS-1:0] dout_q, dout_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;

    logic push, flush, pop, empty, full, pop_last, pop_bit;

    // Address arrives LSB first: new bits enter at the top, so after ADDR_W shifts bit 0 sits at the LSB.
    function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] a, input logic b);
        logic [ADDR_W-1:0] r;
        r = a >> 1;
        r[ADDR_W-1] = b;
        return r;
    endfunction

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign pop   = grant_q && !empty;
    assign {pop_last, pop_bit} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {frame_n, din};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        drop_d  = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    addr_d = shift_in(addr_q, din);
                    if (ADDR_W == 1) begin
                        state_d = S_PAD;
                        cnt_d   = PAD_LAST;
                    end else begin
                        state_d = S_ADDR;
                        cnt_d   = ADDR_LAST;
                    end
                end
            end
            S_ADDR: begin
                if (frame_n) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = shift_in(addr_q, din);
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_PAD;
                        cnt_d   = PAD_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_PAD: begin
                if (frame_n) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (!valid_n) begin
                    if (full && !pop) begin
                        drop_d  = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        push = 1'b1;
                        if (frame_n) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (pop && pop_last) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                flush = 1'b1;
                if (frame_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Once granted, busy is ignored until the final bit leaves the FIFO.
        if ((state_q == S_DATA || state_q == S_DRAIN) && !grant_q && !busy[addr_q]) begin
            grant_d = 1'b1;
        end
        if (pop && pop_last) begin
            grant_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        frameo_d = '1;
        valido_d = '1;
        dout_d   = '0;
        active_d = active_q;
        done_d   = pop && pop_last;
        if (pop) begin
            frameo_d[addr_q] = pop_last;
            valido_d[addr_q] = 1'b0;
            dout_d[addr_q]   = pop_bit;
            active_d         = !pop_last;
        end else if (active_q) begin
            // Input gap while a packet is being replayed: keep the frame open.
            frameo_d[addr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            grant_q  <= 1'b0;
            active_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frameo_q <= '1;
            valido_q <= '1;
            dout_q   <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frameo_q <= frameo_d;
            valido_q <= valido_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign frameo_n = frameo_q;
    assign valido_n = valido_q;
    assign dout     = dout_q;
    assign idle     = (state_q == S_IDLE);
    assign pkt_done = done_q;
    assign pkt_drop = drop_q;
endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: drives serial packets and checks the per-port output stream.
module tb_router_input_port;
    localparam int N      = 16;
    localparam int ADDR_W = 4;
    localparam int PAD    = 5;
    localparam int DEPTH  = 16;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         frame_n = 1'b1;
    logic         valid_n = 1'b1;
    logic         din     = 1'b0;
    logic [N-1:0] busy    = '0;
    logic [N-1:0] frameo_n, valido_n, dout;
    logic         idle, pkt_done, pkt_drop;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int busy_cnt = 0;
    int busy_port = 0;
    int exp_port = 0;
    int first_edge = 0;

    logic obits[$];
    logic oframe[$];
    int   ocyc[$];
    int   ndone = 0, ndrop = 0, gaps = 0, gap_bad = 0, other_act = 0;
    int   done_cyc = -1, drop_cyc = -1;

    router_input_port #(
        .N_PORTS   (N),
        .PAD_CYCLES(PAD),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .frame_n (frame_n),
        .valid_n (valid_n),
        .din     (din),
        .busy    (busy),
        .frameo_n(frameo_n),
        .valido_n(valido_n),
        .dout    (dout),
        .idle    (idle),
        .pkt_done(pkt_done),
        .pkt_drop(pkt_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Output recorder, sampled on the falling edge.
    always @(negedge clk) begin
        for (int p = 0; p < N; p++) begin
            if (p != exp_port && (frameo_n[p] !== 1'b1 || valido_n[p] !== 1'b1 || dout[p] !== 1'b0))
                other_act++;
        end
        if (valido_n[exp_port] === 1'b0) begin
            obits.push_back(dout[exp_port]);
            oframe.push_back(frameo_n[exp_port]);
            ocyc.push_back(ncyc);
        end else if (frameo_n[exp_port] === 1'b0) begin
            gaps++;
            if (dout[exp_port] !== 1'b0) gap_bad++;
        end else if (dout[exp_port] !== 1'b0) begin
            other_act++;
        end
        if (pkt_done === 1'b1) begin
            ndone++;
            done_cyc = ncyc;
        end
        if (pkt_drop === 1'b1) begin
            ndrop++;
            drop_cyc = ncyc;
        end
    end

    task automatic drv(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        busy    = '0;
        if (busy_cnt > 0) begin
            busy[busy_port] = 1'b1;
            busy_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic mon_clear(input int port);
        #1;
        exp_port = port;
        obits.delete();
        oframe.delete();
        ocyc.delete();
        ndone = 0; ndrop = 0; gaps = 0; gap_bad = 0; other_act = 0;
        done_cyc = -1; drop_cyc = -1;
    endtask

    task automatic send_pkt(input int a, input int nbits, input logic [31:0] data,
                            input int gap_at, input int gap_len, input int blen, input int stop);
        int sent;
        for (int i = 0; i < ADDR_W; i++) drv(1'b0, 1'b1, a[i]);
        for (int i = 0; i < PAD; i++) drv(1'b0, 1'b1, 1'b0);
        first_edge = ncyc + 1;
        sent = 0;
        for (int i = 0; i < nbits && sent < stop; i++) begin
            if (i == 0) busy_cnt = blen;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) drv(1'b0, 1'b1, 1'b0);
            end
            drv(i == nbits - 1, 1'b0, data[i]);
            sent++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 100) begin
            drv(1'b1, 1'b1, 1'b0);
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_timeout idle=%b required=1", name, idle);
        end
        repeat (3) drv(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (frameo_n !== '1 || valido_n !== '1) begin
            errors++;
            $display("FAIL reset_frame_valid frameo_n=%h valido_n=%h required=ffff/ffff", frameo_n, valido_n);
        end
        checks++;
        if (dout !== '0) begin
            errors++;
            $display("FAIL reset_dout got=%h required=0000", dout);
        end
        checks++;
        if (idle !== 1'b1 || pkt_done !== 1'b0 || pkt_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags idle=%b done=%b drop=%b required=1/0/0", idle, pkt_done, pkt_drop);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drv(1'b1, 1'b1, 1'b0);
        drv(1'b1, 1'b1, 1'b0);
        checks++;
        if (idle !== 1'b1 || frameo_n !== '1) begin
            errors++;
            $display("FAIL reset_release idle=%b frameo_n=%h required=1/ffff", idle, frameo_n);
        end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        e = 8'hA5;
        mon_clear(5);
        send_pkt(5, 8, 32'hA5, -1, 0, 0, 8);
        wait_idle("basic");
        checks++;
        if (obits.size() != 8) begin
            errors++;
            $display("FAIL basic_count got=%0d required=8", obits.size());
        end
        for (int i = 0; i < 8 && i < obits.size(); i++) begin
            checks++;
            if (obits[i] !== e[i] || oframe[i] !== (i == 7)) begin
                errors++;
                $display("FAIL basic_bit%0d got d=%b f=%b required d=%b f=%b", i, obits[i], oframe[i], e[i], (i == 7));
            end
        end
        checks++;
        if (ocyc.size() < 8 || ocyc[0] != first_edge + 1 || ocyc[7] != first_edge + 8) begin
            errors++;
            $display("FAIL basic_latency first=%0d required=%0d", (ocyc.size() > 0) ? ocyc[0] : -1, first_edge + 1);
        end
        checks++;
        if (ndone != 1 || done_cyc != first_edge + 8) begin
            errors++;
            $display("FAIL basic_done count=%0d at=%0d required 1 at %0d", ndone, done_cyc, first_edge + 8);
        end
        checks++;
        if (other_act != 0 || ndrop != 0 || gaps != 0) begin
            errors++;
            $display("FAIL basic_quiet other=%0d drop=%0d gaps=%0d required 0/0/0", other_act, ndrop, gaps);
        end
    endtask

    task automatic test_busy_stall();
        logic [7:0] e;
        e = 8'hC3;
        busy_port = 3;
        mon_clear(3);
        send_pkt(3, 8, 32'hC3, -1, 0, 10, 8);
        wait_idle("stall");
        checks++;
        if (obits.size() != 8) begin
            errors++;
            $display("FAIL stall_count got=%0d required=8", obits.size());
        end
        for (int i = 0; i < 8 && i < obits.size(); i++) begin
            checks++;
            if (obits[i] !== e[i] || oframe[i] !== (i == 7)) begin
                errors++;
                $display("FAIL stall_bit%0d got d=%b f=%b required d=%b f=%b", i, obits[i], oframe[i], e[i], (i == 7));
            end
        end
        checks++;
        if (ocyc.size() < 8 || ocyc[0] != first_edge + 11 || ocyc[7] != first_edge + 18) begin
            errors++;
            $display("FAIL stall_timing first=%0d required=%0d", (ocyc.size() > 0) ? ocyc[0] : -1, first_edge + 11);
        end
        checks++;
        if (ndone != 1 || other_act != 0 || gaps != 0) begin
            errors++;
            $display("FAIL stall_flags done=%0d other=%0d gaps=%0d required 1/0/0", ndone, other_act, gaps);
        end
    endtask

    task automatic test_overflow();
        busy_port = 7;
        mon_clear(7);
        send_pkt(7, 20, 32'h000ABCDE, -1, 0, 1000, 20);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL ovf_idle got=%b required=1", idle);
        end
        busy_cnt = 0;
        wait_idle("ovf");
        checks++;
        if (ndrop != 1 || drop_cyc != first_edge + 16) begin
            errors++;
            $display("FAIL ovf_drop count=%0d at=%0d required 1 at %0d", ndrop, drop_cyc, first_edge + 16);
        end
        checks++;
        if (obits.size() != 0 || gaps != 0 || other_act != 0 || ndone != 0) begin
            errors++;
            $display("FAIL ovf_quiet bits=%0d gaps=%0d other=%0d done=%0d required 0/0/0/0",
                     obits.size(), gaps, other_act, ndone);
        end
    endtask

    task automatic test_gaps();
        logic [5:0] e;
        int ec[6];
        e  = 6'h2D;
        ec = '{1, 2, 3, 6, 7, 8};
        mon_clear(9);
        send_pkt(9, 6, 32'h2D, 3, 2, 0, 6);
        wait_idle("gap");
        checks++;
        if (obits.size() != 6) begin
            errors++;
            $display("FAIL gap_count got=%0d required=6", obits.size());
        end
        for (int i = 0; i < 6 && i < obits.size(); i++) begin
            checks++;
            if (obits[i] !== e[i] || oframe[i] !== (i == 5) || ocyc[i] != first_edge + ec[i]) begin
                errors++;
                $display("FAIL gap_bit%0d got d=%b f=%b t=%0d required d=%b f=%b t=%0d",
                         i, obits[i], oframe[i], ocyc[i], e[i], (i == 5), first_edge + ec[i]);
            end
        end
        checks++;
        if (gaps != 2 || gap_bad != 0) begin
            errors++;
            $display("FAIL gap_hold gaps=%0d bad=%0d required 2/0", gaps, gap_bad);
        end
        checks++;
        if (ndone != 1 || done_cyc != first_edge + 8 || other_act != 0) begin
            errors++;
            $display("FAIL gap_done count=%0d at=%0d other=%0d required 1 at %0d other 0",
                     ndone, done_cyc, other_act, first_edge + 8);
        end
    endtask

    task automatic test_abort();
        logic [3:0] e;
        e = 4'h6;
        mon_clear(12);
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_drop !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL abort_addr drop=%b idle=%b required 1/1", pkt_drop, idle);
        end
        repeat (2) drv(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < ADDR_W + 2; i++) drv(1'b0, 1'b1, 1'b1);
        drv(1'b1, 1'b1, 1'b0);
        checks++;
        if (pkt_drop !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL abort_pad drop=%b idle=%b required 1/1", pkt_drop, idle);
        end
        repeat (2) drv(1'b1, 1'b1, 1'b0);
        checks++;
        if (ndrop != 2 || obits.size() != 0 || other_act != 0) begin
            errors++;
            $display("FAIL abort_quiet drops=%0d bits=%0d other=%0d required 2/0/0", ndrop, obits.size(), other_act);
        end
        send_pkt(12, 4, 32'h6, -1, 0, 0, 4);
        wait_idle("abort");
        checks++;
        if (obits.size() != 4 || ndone != 1 || ndrop != 2) begin
            errors++;
            $display("FAIL abort_next_count bits=%0d done=%0d drops=%0d required 4/1/2", obits.size(), ndone, ndrop);
        end
        for (int i = 0; i < 4 && i < obits.size(); i++) begin
            checks++;
            if (obits[i] !== e[i] || oframe[i] !== (i == 3)) begin
                errors++;
                $display("FAIL abort_next_bit%0d got d=%b f=%b required d=%b f=%b", i, obits[i], oframe[i], e[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        e = 8'h5A;
        mon_clear(2);
        send_pkt(2, 8, 32'h5A, -1, 0, 0, 5);
        checks++;
        if (valido_n[2] !== 1'b0 || dout[2] !== 1'b1 || frameo_n[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre v=%b d=%b f=%b required 0/1/0", valido_n[2], dout[2], frameo_n[2]);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (frameo_n !== '1 || valido_n !== '1 || dout !== '0 || pkt_done !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs f=%h v=%h d=%h done=%b idle=%b required ffff/ffff/0000/0/1",
                     frameo_n, valido_n, dout, pkt_done, idle);
        end
        frame_n = 1'b1;
        valid_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) drv(1'b1, 1'b1, 1'b0);
        checks++;
        if (ndone != 0 || obits.size() != 4 || ndrop != 0) begin
            errors++;
            $display("FAIL rst_mid_abort done=%0d bits=%0d drop=%0d required 0/4/0", ndone, obits.size(), ndrop);
        end
        mon_clear(2);
        send_pkt(2, 8, 32'h5A, -1, 0, 0, 8);
        wait_idle("rst_mid");
        checks++;
        if (obits.size() != 8 || ndone != 1) begin
            errors++;
            $display("FAIL rst_mid_fresh bits=%0d done=%0d required 8/1", obits.size(), ndone);
        end
        for (int i = 0; i < 8 && i < obits.size(); i++) begin
            checks++;
            if (obits[i] !== e[i] || oframe[i] !== (i == 7)) begin
                errors++;
                $display("FAIL rst_mid_bit%0d got d=%b f=%b required d=%b f=%b", i, obits[i], oframe[i], e[i], (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_overflow();
        test_gaps();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
